alu_result_fifo: RTL
====================

ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of FIFO entries; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  the reset; synchronous, active-high.
REQ-004 The block SHALL have port in_valid  input  1  ALU result present on in_result/in_carry/in_sel.
REQ-005 The block SHALL have port in_ready  output  1  the FIFO can accept an entry this cycle.
REQ-006 The block SHALL have port in_result  input  16  combinational ALU output word.
REQ-007 The block SHALL have port in_carry  input  1  ALU carry-out flag.
REQ-008 The block SHALL have port in_sel  input  4  ALU operation select that produced in_result.
REQ-009 The block SHALL have port out_valid  output  1  head entry available.
REQ-010 The block SHALL have port out_ready  input  1  consumer takes the head entry this cycle.
REQ-011 The block SHALL have port out_result  output  16  head result word.
REQ-012 The block SHALL have port out_carry  output  1  head carry flag.
REQ-013 The block SHALL have port out_zero  output  1  head result equals 16'h0000.
REQ-014 The block SHALL have port out_neg  output  1  head result bit 15.
REQ-015 The block SHALL have port out_sel  output  4  head operation select.
REQ-016 The block SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-017 The block SHALL have port carry_cnt  output  8  saturating count of accepted entries with carry set.

Function
REQ-018 Push SHALL occur on a cycle with in_valid=1 and in_ready=1; pop SHALL occur on a cycle with out_valid=1 and out_ready=1.
REQ-019 in_ready SHALL equal (count != DEPTH), driven only from registered state; there is no same-cycle pass-through when full.
REQ-020 out_valid SHALL equal (count != 0); an entry pushed in cycle N SHALL first be visible on the outputs in cycle N+1 (latency 1, no bypass when empty).
REQ-021 At push, the stored entry SHALL be {in_result, in_carry, (in_result==0), in_result[15], in_sel}, with zero/neg computed at write time.
REQ-022 out_* data SHALL reflect the entry at the read pointer and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 Write and read pointers SHALL each advance by one per push/pop, wrapping modulo DEPTH.
REQ-024 Push-only SHALL increment count; pop-only SHALL decrement count; simultaneous push and pop SHALL leave count unchanged.
REQ-025 When full, in_valid=1 SHALL NOT alter state; when empty, out_ready=1 SHALL NOT alter state.
REQ-026 When full and popped, in_ready SHALL return to 1 on the following cycle.
REQ-027 carry_cnt SHALL increment by 1 on each push with in_carry=1 and SHALL saturate at 8'hFF.
REQ-028 out_* data fields SHALL be don't-care while out_valid=0; the bench SHALL not check them in that state.

Reset
REQ-029 While rst=1 at a clock edge, pointers, count and carry_cnt SHALL clear to 0; out_valid SHALL be 0 and in_ready SHALL be 1 in the next cycle.
REQ-030 A push or pop coinciding with rst=1 SHALL be discarded; reset SHALL take priority over all other updates.
REQ-031 Storage array contents SHALL not require reset.

Verification
REQ-032 After reset, push 16'h0005/carry 0/sel 4'h0 at cycle 1 -> out_valid=1 at cycle 2 with out_result=16'h0005, out_zero=0, out_neg=0, count=1.
REQ-033 With out_ready=0, push DEPTH=4 entries 16'h0001..16'h0004 -> in_ready=0 and count=4; a fifth in_valid is ignored; then drain with out_ready=1 -> outputs 0001,0002,0003,0004 in order, then out_valid=0.
REQ-034 Push 16'h0000 (sel 4'h1) then 16'h8000 (sel 4'h6) -> first head out_zero=1/out_neg=0/out_sel=1; second out_zero=0/out_neg=1/out_sel=6.
REQ-035 With count=2, hold in_valid=1 and out_ready=1 for 10 cycles -> count stays 2, pointers wrap, outputs preserve push order.
REQ-036 Push 300 entries with in_carry=1 while continuously popping -> carry_cnt reaches 8'hFF and holds.
REQ-037 With count=3, assert rst=1 for one cycle alongside in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1, carry_cnt=0.

Source files
------------

// File: rtl/alu_result_fifo.sv
// ALU result FIFO: buffers ALU results with write-time zero/neg flags.
// Ports: clk/rst, in_* push side, out_* pop side, count, carry_cnt.
module alu_result_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                in_result,
    input  logic                       in_carry,
    input  logic [3:0]                 in_sel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_result,
    output logic                       out_carry,
    output logic                       out_zero,
    output logic                       out_neg,
    output logic [3:0]                 out_sel,
    output logic [$clog2(DEPTH):0]     count,
    output logic [7:0]                 carry_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 23;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_carry_cnt;

    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_wdata;
    logic [EW-1:0] w_head;

    assign in_ready  = (r_count != CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // Flags are computed once at write time so the read side is pure storage.
    assign w_wdata = {in_result, in_carry, (in_result == 16'h0000),
                      in_result[15], in_sel};

    // Storage needs no reset; pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wptr] <= w_wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally at AW bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_carry_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && in_carry && (r_carry_cnt != 8'hFF)) begin
                r_carry_cnt <= r_carry_cnt + 1'b1;
            end
        end
    end

    assign w_head     = r_mem[r_rptr];
    assign out_result = w_head[22:7];
    assign out_carry  = w_head[6];
    assign out_zero   = w_head[5];
    assign out_neg    = w_head[4];
    assign out_sel    = w_head[3:0];
    assign count      = r_count;
    assign carry_cnt  = r_carry_cnt;

endmodule
